ysyx_lsu: RTL and testbench
===========================

YSYX_LSU -- requirements
Module: ysyx_lsu

Interface
REQ-001 SHALL have parameter BIT_W, default `YSYX_W_WIDTH (32), data/address width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have EXU-side inputs:
- lsu_avalid 1, request valid
- addr BIT_W, byte address
- wdata BIT_W, store data
- ren 1, load
- wen 1, store
- func3 3, access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
REQ-005 SHALL have EXU-side outputs:
- rdata_o BIT_W, extended load data
- rvalid_o 1, load done
- wready_o 1, store done
- fault_o 1, bus error
REQ-006 SHALL have AXI4-Lite master read channels:
- araddr BIT_W, arvalid o, arready i
- rdata BIT_W i, rresp 2 i, rvalid i, rready o
REQ-007 SHALL have AXI4-Lite master write channels:
- awaddr BIT_W, awvalid o, awready i
- wdata_o BIT_W, wstrb BIT_W/8, wvalid o, wready i
- bresp 2 i, bvalid i, bready o

Function
REQ-008 SHALL implement FSM states IDLE, RD_A, RD_D, WR_AW, WR_B, DONE.
REQ-009 In IDLE with lsu_avalid&ren SHALL latch addr/func3 and enter RD_A next cycle; ren has priority when ren&wen are both high.
REQ-010 In IDLE with lsu_avalid&wen&!ren SHALL latch addr/wdata/func3 and enter WR_AW.
REQ-011 In RD_A SHALL drive arvalid=1 with araddr={addr[BIT_W-1:2],2'b00}; on arready go to RD_D.
REQ-012 In RD_D SHALL drive rready=1; on rvalid latch the extracted lane and go to DONE.
REQ-013 Lane extraction SHALL shift bus data right by 8*addr[1:0]; B/H sign-extend, BU/HU zero-extend, W passes unchanged.
REQ-014 In WR_AW SHALL assert awvalid and wvalid independently, deasserting each after its own handshake; when both have completed (same or different cycles) go to WR_B.
REQ-015 wstrb SHALL be 0001/0011/1111 shifted left by addr[1:0]; wdata_o SHALL be store data shifted left by 8*addr[1:0].
REQ-016 In WR_B SHALL drive bready=1; on bvalid go to DONE.
REQ-017 In DONE SHALL pulse exactly one of rvalid_o/wready_o for one cycle, then return to IDLE.
REQ-018 rdata_o SHALL hold the last load value until the next load completes.
REQ-019 A new request SHALL NOT be accepted in the DONE cycle; lsu_avalid is ignored outside IDLE.
REQ-020 Minimum latency SHALL be 4 cycles from request to done pulse with zero-wait slave responses.
REQ-021 All bus valid outputs SHALL be registered; inputs SHALL NOT combinationally reach AXI outputs.

Reset
REQ-022 On rst the FSM SHALL enter IDLE next cycle and all valid/ready outputs, wstrb, and fault_o SHALL read 0.
REQ-023 rdata_o SHALL reset to 0.
REQ-024 Reset mid-transaction SHALL abandon the transaction without completing any handshake and produce no done pulse.

Configuration
REQ-025 With YSYX_LSU_FAULT_EN defined, fault_o SHALL pulse in DONE together with rvalid_o/wready_o when the latched rresp/bresp != 2'b00; without it, fault_o SHALL be tied 0 and resp inputs ignored.

Structure
REQ-026 The FSM state enum and func3 size encodings SHALL live in the shared ysyx package/header.
REQ-027 Lane extraction/extension SHALL be a sub-module ysyx_lsu_align used for both load and store alignment.

Verification
REQ-028 The bench SHALL cover each of the following directed scenarios:
- LB at addr 0x...3, bus rdata 0x80FF_FF11 -> rdata_o=0xFFFF_FF80, rvalid_o single pulse.
- LHU at addr 0x...2, rdata 0xBEEF_1234 -> rdata_o=0x0000_BEEF.
- SB 0xAB at addr 0x...1 -> wstrb=0010, wdata_o=0x0000_AB00; wready_o pulses after bvalid.
- Store with awready 3 cycles before wready -> single wready_o pulse only after both handshakes and bvalid.
- rst asserted in RD_D -> FSM in IDLE, rready=0, no rvalid_o pulse.
- YSYX_LSU_FAULT_EN with rresp=2'b10 -> fault_o=1 in same cycle as rvalid_o.

Source files
------------

// File: rtl/ysyx_lsu_pkg.sv
// -----------------------------------------------------------------------------
// ysyx_lsu_pkg
// Shared definitions for the load/store unit:
//   - `YSYX_W_WIDTH : default data/address width (32) when not set by the build
//   - lsu_state_e   : LSU bus FSM states
//   - F3_*          : func3 access size / sign encodings
//   - RESP_OKAY     : AXI response code for a successful transfer
// Build option: YSYX_LSU_FAULT_EN (consumed by ysyx_lsu) reports non-OKAY
// responses on fault_o.
// -----------------------------------------------------------------------------
`ifndef YSYX_W_WIDTH
`define YSYX_W_WIDTH 32
`endif

package ysyx_lsu_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_A  = 3'd1,
      RD_D  = 3'd2,
      WR_AW = 3'd3,
      WR_B  = 3'd4,
      DONE  = 3'd5
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_lsu_align.sv
// -----------------------------------------------------------------------------
// ysyx_lsu_align
// Byte-lane alignment shared by the load and store paths.
//   off     in   byte offset within the bus word (addr[1:0])
//   func3   in   access size / sign (F3_* encodings)
//   ld_bus  in   raw bus read data
//   ld_data out  load lane shifted down and sign/zero-extended
//   st_data in   register store data (lane 0 aligned)
//   st_bus  out  store data shifted up into its byte lanes
//   st_strb out  byte strobes for the store
// -----------------------------------------------------------------------------
`ifndef YSYX_W_WIDTH
`define YSYX_W_WIDTH 32
`endif

module ysyx_lsu_align
   import ysyx_lsu_pkg::*;
#(
   parameter int BIT_W = `YSYX_W_WIDTH
) (
   input  logic [1:0]         off,
   input  logic [2:0]         func3,
   input  logic [BIT_W-1:0]   ld_bus,
   output logic [BIT_W-1:0]   ld_data,
   input  logic [BIT_W-1:0]   st_data,
   output logic [BIT_W-1:0]   st_bus,
   output logic [BIT_W/8-1:0] st_strb
);

   logic [4:0]         sh_amt;
   logic [BIT_W-1:0]   ld_shift;
   logic [BIT_W/8-1:0] strb_base;

   assign sh_amt   = {off, 3'b000};
   assign ld_shift = ld_bus >> sh_amt;

   // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      ld_data = ld_shift;
      case (func3)
         F3_B:    ld_data = {{(BIT_W-8){ld_shift[7]}}, ld_shift[7:0]};
         F3_H:    ld_data = {{(BIT_W-16){ld_shift[15]}}, ld_shift[15:0]};
         F3_BU:   ld_data = {{(BIT_W-8){1'b0}}, ld_shift[7:0]};
         F3_HU:   ld_data = {{(BIT_W-16){1'b0}}, ld_shift[15:0]};
         default: ld_data = ld_shift;
      endcase
   end

   // Store size only depends on func3[1:0]; the unsigned variants have no store meaning.
   always_comb begin
      strb_base = '1;
      case (func3[1:0])
         2'b00:   strb_base = {{(BIT_W/8-1){1'b0}}, 1'b1};
         2'b01:   strb_base = {{(BIT_W/8-2){1'b0}}, 2'b11};
         default: strb_base = '1;
      endcase
   end

   assign st_strb = strb_base << off;
   assign st_bus  = st_data << sh_amt;

endmodule

// File: rtl/ysyx_lsu.sv
// -----------------------------------------------------------------------------
// ysyx_lsu
// Load/store unit: turns one EXU request into an AXI4-Lite read or write.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   lsu_avalid, addr, wdata, request valid, byte address, store data,
//   ren, wen, func3          load / store select (load wins), size/sign
//   rdata_o, rvalid_o,       extended load data (held), load-done pulse,
//   wready_o, fault_o        store-done pulse, bus error pulse
//   ar*/r*                   AXI4-Lite read address / data channels
//   aw*/w*/b*                AXI4-Lite write address / data / response
// Build option: define YSYX_LSU_FAULT_EN to report non-OKAY rresp/bresp on
// fault_o alongside the done pulse; otherwise fault_o is tied 0.
// All AXI valid/ready outputs come straight from flops; address, data and
// strobes derive from latched request registers only.
// -----------------------------------------------------------------------------
`ifndef YSYX_W_WIDTH
`define YSYX_W_WIDTH 32
`endif

module ysyx_lsu
   import ysyx_lsu_pkg::*;
#(
   parameter int BIT_W = `YSYX_W_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   // EXU side
   input  logic               lsu_avalid,
   input  logic [BIT_W-1:0]   addr,
   input  logic [BIT_W-1:0]   wdata,
   input  logic               ren,
   input  logic               wen,
   input  logic [2:0]         func3,
   output logic [BIT_W-1:0]   rdata_o,
   output logic               rvalid_o,
   output logic               wready_o,
   output logic               fault_o,
   // AXI4-Lite read
   output logic [BIT_W-1:0]   araddr,
   output logic               arvalid,
   input  logic               arready,
   input  logic [BIT_W-1:0]   rdata,
   input  logic [1:0]         rresp,
   input  logic               rvalid,
   output logic               rready,
   // AXI4-Lite write
   output logic [BIT_W-1:0]   awaddr,
   output logic               awvalid,
   input  logic               awready,
   output logic [BIT_W-1:0]   wdata_o,
   output logic [BIT_W/8-1:0] wstrb,
   output logic               wvalid,
   input  logic               wready,
   input  logic [1:0]         bresp,
   input  logic               bvalid,
   output logic               bready
);

   lsu_state_e         state_q, state_d;
   logic [BIT_W-1:0]   addr_q, addr_d;
   logic [BIT_W-1:0]   wdata_q, wdata_d;
   logic [2:0]         func3_q, func3_d;
   logic [BIT_W-1:0]   rdata_o_q, rdata_o_d;
   logic               arvalid_q, arvalid_d;
   logic               rready_q, rready_d;
   logic               awvalid_q, awvalid_d;
   logic               wvalid_q, wvalid_d;
   logic               bready_q, bready_d;
   logic               aw_done_q, aw_done_d;
   logic               w_done_q, w_done_d;
   logic               rvalid_o_q, rvalid_o_d;
   logic               wready_o_q, wready_o_d;
   logic               fault_q, fault_d;

   logic               ar_hs, r_hs, aw_hs, w_hs, b_hs;
   logic               aw_ok, w_ok;
   logic [BIT_W-1:0]   ld_data;
   logic [BIT_W-1:0]   st_bus;
   logic [BIT_W/8-1:0] st_strb;

   assign ar_hs = arvalid_q & arready;
   assign r_hs  = rready_q  & rvalid;
   assign aw_hs = awvalid_q & awready;
   assign w_hs  = wvalid_q  & wready;
   assign b_hs  = bready_q  & bvalid;

   // A write channel counts as finished once its handshake has happened,
   // whether in an earlier cycle or in this one.
   assign aw_ok = aw_done_q | aw_hs;
   assign w_ok  = w_done_q  | w_hs;

   ysyx_lsu_align #(.BIT_W(BIT_W)) u_align (
      .off     (addr_q[1:0]),
      .func3   (func3_q),
      .ld_bus  (rdata),
      .ld_data (ld_data),
      .st_data (wdata_q),
      .st_bus  (st_bus),
      .st_strb (st_strb)
   );

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of every other flop.
      if (rst) begin
         state_q    <= IDLE;
         // NOTE: request and load-data registers are reset as well so every output reads a defined value after rst.
         addr_q     <= '0;
         wdata_q    <= '0;
         func3_q    <= '0;
         rdata_o_q  <= '0;
         arvalid_q  <= 1'b0;
         rready_q   <= 1'b0;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         bready_q   <= 1'b0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
         rvalid_o_q <= 1'b0;
         wready_o_q <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         func3_q    <= func3_d;
         rdata_o_q  <= rdata_o_d;
         arvalid_q  <= arvalid_d;
         rready_q   <= rready_d;
         awvalid_q  <= awvalid_d;
         wvalid_q   <= wvalid_d;
         bready_q   <= bready_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
         rvalid_o_q <= rvalid_o_d;
         wready_o_q <= wready_o_d;
         fault_q    <= fault_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (lsu_avalid && ren)      state_d = RD_A;
            else if (lsu_avalid && wen) state_d = WR_AW;
         end
         RD_A:    if (ar_hs) state_d = RD_D;
         RD_D:    if (r_hs)  state_d = DONE;
         WR_AW:   if (aw_ok && w_ok) state_d = WR_B;
         WR_B:    if (b_hs)  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- registered FSM outputs ----------------
   // Each valid/ready flop is loaded with the value it must show in the
   // state being entered, so the outputs need no decode after the flop.
   always_comb begin
      arvalid_d  = (state_d == RD_A);
      rready_d   = (state_d == RD_D);
      bready_d   = (state_d == WR_B);
      rvalid_o_d = (state_q == RD_D) && (state_d == DONE);
      wready_o_d = (state_q == WR_B) && (state_d == DONE);
      awvalid_d  = 1'b0;
      wvalid_d   = 1'b0;
      aw_done_d  = 1'b0;
      w_done_d   = 1'b0;
      if (state_q == IDLE && state_d == WR_AW) begin
         awvalid_d = 1'b1;
         wvalid_d  = 1'b1;
      end else if (state_q == WR_AW && state_d == WR_AW) begin
         // Each channel drops its valid after its own handshake.
         awvalid_d = awvalid_q & ~awready;
         wvalid_d  = wvalid_q  & ~wready;
         aw_done_d = aw_ok;
         w_done_d  = w_ok;
      end
   end

   // ---------------- request / load datapath ----------------
   always_comb begin
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      func3_d   = func3_q;
      rdata_o_d = rdata_o_q;
      if (state_q == IDLE && lsu_avalid && (ren || wen)) begin
         addr_d  = addr;
         func3_d = func3;
         if (!ren) wdata_d = wdata;
      end
      if (state_q == RD_D && r_hs) rdata_o_d = ld_data;
   end

`ifdef YSYX_LSU_FAULT_EN
   // The error flag is loaded on the same edge as the done pulse.
   always_comb begin
      fault_d = 1'b0;
      if (state_q == RD_D && r_hs)      fault_d = (rresp != RESP_OKAY);
      else if (state_q == WR_B && b_hs) fault_d = (bresp != RESP_OKAY);
   end
`else
   logic unused_resp;
   assign unused_resp = ^{rresp, bresp};
   assign fault_d     = 1'b0;
`endif

   // ---------------- outputs ----------------
   assign rdata_o  = rdata_o_q;
   assign rvalid_o = rvalid_o_q;
   assign wready_o = wready_o_q;
   assign fault_o  = fault_q;

   assign araddr   = {addr_q[BIT_W-1:2], 2'b00};
   assign arvalid  = arvalid_q;
   assign rready   = rready_q;

   assign awaddr   = {addr_q[BIT_W-1:2], 2'b00};
   assign awvalid  = awvalid_q;
   assign wvalid   = wvalid_q;
   assign wdata_o  = st_bus;
   assign wstrb    = wvalid_q ? st_strb : '0;
   assign bready   = bready_q;

endmodule

// File: tb/tb_ysyx_lsu.sv
// -----------------------------------------------------------------------------
// tb_ysyx_lsu
// Self-checking bench for ysyx_lsu: a configurable-latency AXI4-Lite slave,
// directed scenarios followed by randomized loads/stores, each checked
// against byte-lane arithmetic. Build option YSYX_LSU_FAULT_EN selects the
// expected fault_o behaviour.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ysyx_lsu;
   import ysyx_lsu_pkg::*;

   localparam int W      = 32;
   localparam int BUDGET = 40;
`ifdef YSYX_LSU_FAULT_EN
   localparam bit FAULT_EN = 1'b1;
`else
   localparam bit FAULT_EN = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          lsu_avalid;
   logic [W-1:0]  addr;
   logic [W-1:0]  wdata;
   logic          ren;
   logic          wen;
   logic [2:0]    func3;
   logic [W-1:0]  rdata_o;
   logic          rvalid_o;
   logic          wready_o;
   logic          fault_o;
   logic [W-1:0]  araddr;
   logic          arvalid;
   logic          arready;
   logic [W-1:0]  rdata;
   logic [1:0]    rresp;
   logic          rvalid;
   logic          rready;
   logic [W-1:0]  awaddr;
   logic          awvalid;
   logic          awready;
   logic [W-1:0]  wdata_o;
   logic [W/8-1:0] wstrb;
   logic          wvalid;
   logic          wready;
   logic [1:0]    bresp;
   logic          bvalid;
   logic          bready;

   int checks = 0;
   int errors = 0;

   // slave knobs and observations
   int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
   logic [31:0] s_rdata = '0;
   logic [1:0]  s_rresp = '0, s_bresp = '0;
   int          ar_hs_n = 0, r_hs_n = 0, aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0;
   int          rvalid_pulses = 0, wready_pulses = 0;
   logic [31:0] cap_araddr = '0, cap_awaddr = '0, cap_wdata = '0;
   logic [3:0]  cap_wstrb = '0;
   logic [31:0] last_load = '0;

   logic [2:0] ld_f3 [5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};

   ysyx_lsu #(.BIT_W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .lsu_avalid (lsu_avalid),
      .addr       (addr),
      .wdata      (wdata),
      .ren        (ren),
      .wen        (wen),
      .func3      (func3),
      .rdata_o    (rdata_o),
      .rvalid_o   (rvalid_o),
      .wready_o   (wready_o),
      .fault_o    (fault_o),
      .araddr     (araddr),
      .arvalid    (arvalid),
      .arready    (arready),
      .rdata      (rdata),
      .rresp      (rresp),
      .rvalid     (rvalid),
      .rready     (rready),
      .awaddr     (awaddr),
      .awvalid    (awvalid),
      .awready    (awready),
      .wdata_o    (wdata_o),
      .wstrb      (wstrb),
      .wvalid     (wvalid),
      .wready     (wready),
      .bresp      (bresp),
      .bvalid     (bvalid),
      .bready     (bready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3,
                                            input logic [31:0] bus);
      logic [31:0] v;
      v = bus >> (8 * a[1:0]);
      case (f3)
         3'b000: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
         3'b001: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
         3'b100: v = v % 256;
         3'b101: v = v % 65536;
         default: ;
      endcase
      return v;
   endfunction

   function automatic logic [3:0] ref_strb(input logic [31:0] a, input logic [2:0] f3);
      int n;
      n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      return 4'(((1 << n) - 1) << a[1:0]);
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [31:0] a, input logic [31:0] d);
      return d << (8 * a[1:0]);
   endfunction

   // ---------------- AXI4-Lite slave (acts on the falling edge) ----------------
   initial begin : slave
      int ar_c, r_c, aw_c, w_c, b_c;
      ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
      forever begin
         @(negedge clk);
         if (rvalid_o) rvalid_pulses++;
         if (wready_o) wready_pulses++;

         arready = 1'b0;
         if (arvalid && !rst) begin
            if (ar_c >= ar_wait) begin
               arready = 1'b1; ar_hs_n++; cap_araddr = araddr; ar_c = 0;
            end else ar_c++;
         end else ar_c = 0;

         rvalid = 1'b0; rdata = $urandom; rresp = 2'($urandom);
         if (rready && !rst) begin
            if (r_c >= r_wait) begin
               rvalid = 1'b1; rdata = s_rdata; rresp = s_rresp; r_hs_n++; r_c = 0;
            end else r_c++;
         end else r_c = 0;

         awready = 1'b0;
         if (awvalid && !rst) begin
            if (aw_c >= aw_wait) begin
               awready = 1'b1; aw_hs_n++; cap_awaddr = awaddr; aw_c = 0;
            end else aw_c++;
         end else aw_c = 0;

         wready = 1'b0;
         if (wvalid && !rst) begin
            if (w_c >= w_wait) begin
               wready = 1'b1; w_hs_n++; cap_wdata = wdata_o; cap_wstrb = wstrb; w_c = 0;
            end else w_c++;
         end else w_c = 0;

         bvalid = 1'b0; bresp = 2'($urandom);
         if (bready && !rst) begin
            if (b_c >= b_wait) begin
               bvalid = 1'b1; bresp = s_bresp; b_hs_n++; b_c = 0;
            end else b_c++;
         end else b_c = 0;
      end
   end

   // ---------------- helpers ----------------
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic garbage();
      lsu_avalid = 1'($urandom);
      ren        = 1'($urandom);
      wen        = 1'($urandom);
      addr       = $urandom;
      wdata      = $urandom;
      func3      = 3'($urandom);
   endtask

   task automatic recover();
      lsu_avalid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      last_load = '0;
      step();
   endtask

   task automatic do_load(input string nm, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] bus, input logic [1:0] resp,
                          input int arw, input int rw, input bit both, input bit poke);
      logic [31:0] exp_d;
      int cyc, rp0, wp0, ar0, r0, aw0;
      exp_d = ref_load(a, f3, bus);
      ar_wait = arw; r_wait = rw; s_rdata = bus; s_rresp = resp;
      rp0 = rvalid_pulses; wp0 = wready_pulses; ar0 = ar_hs_n; r0 = r_hs_n; aw0 = aw_hs_n;
      cap_araddr = 32'hDEAD_BEEF;
      lsu_avalid = 1'b1; ren = 1'b1; wen = both; addr = a; func3 = f3; wdata = $urandom;
      step();
      cyc = 1;
      while (!(rvalid_o || wready_o) && cyc < BUDGET) begin
         garbage();
         step();
         cyc++;
      end
      lsu_avalid = poke; ren = 1'b1; wen = 1'b0; addr = $urandom;
      check({nm, " latency"}, 32'(cyc), 32'(3 + arw + rw));
      if (cyc >= BUDGET) begin
         recover();
         return;
      end
      check({nm, " rvalid_o"}, 32'(rvalid_o), 32'd1);
      check({nm, " wready_o"}, 32'(wready_o), 32'd0);
      check({nm, " rdata_o"}, rdata_o, exp_d);
      check({nm, " fault_o"}, 32'(fault_o), 32'(FAULT_EN && resp != 2'b00));
      check({nm, " araddr"}, cap_araddr, {a[31:2], 2'b00});
      check({nm, " ar/r handshakes"}, 32'((ar_hs_n - ar0) * 16 + (r_hs_n - r0)), 32'h11);
      check({nm, " aw handshakes"}, 32'(aw_hs_n - aw0), 32'd0);
      step();
      lsu_avalid = 1'b0;
      check({nm, " rvalid_o drop"}, 32'(rvalid_o), 32'd0);
      check({nm, " fault_o drop"}, 32'(fault_o), 32'd0);
      check({nm, " done pulses"}, 32'((rvalid_pulses - rp0) * 16 + (wready_pulses - wp0)), 32'h10);
      check({nm, " rdata_o hold"}, rdata_o, exp_d);
      if (poke) begin
         step();
         step();
         step();
         check({nm, " done-cycle req arvalid"}, 32'(arvalid), 32'd0);
         check({nm, " done-cycle req ar count"}, 32'(ar_hs_n - ar0), 32'd1);
      end
      last_load = exp_d;
   endtask

   task automatic do_store(input string nm, input logic [31:0] a, input logic [2:0] f3,
                           input logic [31:0] d, input logic [1:0] resp,
                           input int aww, input int ww, input int bw);
      int cyc, rp0, wp0, ar0, aw0, w0, b0, lat;
      aw_wait = aww; w_wait = ww; b_wait = bw; s_bresp = resp;
      rp0 = rvalid_pulses; wp0 = wready_pulses; ar0 = ar_hs_n;
      aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n;
      cap_wdata = 32'hDEAD_BEEF; cap_wstrb = 4'h0;
      lat = 3 + ((aww > ww) ? aww : ww) + bw;
      lsu_avalid = 1'b1; ren = 1'b0; wen = 1'b1; addr = a; func3 = f3; wdata = d;
      step();
      cyc = 1;
      while (!(rvalid_o || wready_o) && cyc < BUDGET) begin
         garbage();
         step();
         cyc++;
      end
      lsu_avalid = 1'b0;
      check({nm, " latency"}, 32'(cyc), 32'(lat));
      if (cyc >= BUDGET) begin
         recover();
         return;
      end
      check({nm, " wready_o"}, 32'(wready_o), 32'd1);
      check({nm, " rvalid_o"}, 32'(rvalid_o), 32'd0);
      check({nm, " fault_o"}, 32'(fault_o), 32'(FAULT_EN && resp != 2'b00));
      check({nm, " aw/w/b handshakes"},
            32'((aw_hs_n - aw0) * 256 + (w_hs_n - w0) * 16 + (b_hs_n - b0)), 32'h111);
      check({nm, " ar handshakes"}, 32'(ar_hs_n - ar0), 32'd0);
      check({nm, " wstrb"}, 32'(cap_wstrb), 32'(ref_strb(a, f3)));
      check({nm, " wdata_o"}, cap_wdata, ref_wdata(a, d));
      check({nm, " rdata_o kept"}, rdata_o, last_load);
      step();
      check({nm, " wready_o drop"}, 32'(wready_o), 32'd0);
      check({nm, " done pulses"}, 32'((rvalid_pulses - rp0) * 16 + (wready_pulses - wp0)), 32'h01);
   endtask

   // ---------------- stimulus ----------------
   initial begin : main
      int rp0, cyc;
      rst = 1'b1; lsu_avalid = 1'b0; addr = '0; wdata = '0; ren = 1'b0; wen = 1'b0; func3 = '0;
      step();
      step();
      check("reset valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
      check("reset done/fault", 32'({rvalid_o, wready_o, fault_o}), 32'd0);
      check("reset wstrb", 32'(wstrb), 32'd0);
      check("reset rdata_o", rdata_o, 32'd0);
      check("reset state", 32'(dut.state_q), 32'(IDLE));
      rst = 1'b0;
      step();

      // directed loads
      do_load("lb_off3", 32'h0000_1003, F3_B, 32'h80FF_FF11, 2'b00, 0, 0, 1'b0, 1'b0);
      do_load("lhu_off2", 32'h0000_2002, F3_HU, 32'hBEEF_1234, 2'b00, 0, 0, 1'b0, 1'b0);
      do_load("lh_off0", 32'h0000_2000, F3_H, 32'h1234_8001, 2'b00, 1, 2, 1'b0, 1'b0);
      do_load("lw_ren_wen", 32'h0000_3000, F3_W, 32'hCAFE_F00D, 2'b00, 0, 1, 1'b1, 1'b0);
      do_load("lbu_done_req", 32'h0000_4002, F3_BU, 32'h00C3_0000, 2'b00, 2, 0, 1'b0, 1'b1);

      // directed stores
      do_store("sb_off1", 32'h0000_3001, F3_B, 32'h0000_00AB, 2'b00, 0, 0, 2);
      do_store("sw_aw_first", 32'h0000_5000, F3_W, 32'h1357_9BDF, 2'b00, 0, 3, 0);
      do_store("sh_w_first", 32'h0000_6002, F3_H, 32'hFFFF_A55A, 2'b00, 2, 0, 1);

      // reset while waiting for read data
      ar_wait = 0; r_wait = 10000;
      rp0 = rvalid_pulses;
      lsu_avalid = 1'b1; ren = 1'b1; wen = 1'b0; addr = 32'h0000_0040; func3 = F3_W;
      step();
      lsu_avalid = 1'b0;
      cyc = 0;
      while (!rready && cyc < BUDGET) begin
         step();
         cyc++;
      end
      check("rst_rdd reached rready", 32'(rready), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      r_wait = 0;
      check("rst_rdd state", 32'(dut.state_q), 32'(IDLE));
      check("rst_rdd rready", 32'(rready), 32'd0);
      check("rst_rdd outputs", 32'({arvalid, awvalid, wvalid, bready, rvalid_o, wready_o, fault_o}), 32'd0);
      check("rst_rdd rdata_o", rdata_o, 32'd0);
      last_load = '0;
      repeat (5) step();
      check("rst_rdd no pulse", 32'(rvalid_pulses - rp0), 32'd0);

      // error responses
      do_load("lw_slverr", 32'h0000_7000, F3_W, 32'h0BAD_0BAD, 2'b10, 0, 0, 1'b0, 1'b0);
      do_store("sw_decerr", 32'h0000_7004, F3_W, 32'h0000_0001, 2'b11, 1, 1, 1);
      do_load("lw_okay", 32'h0000_7008, F3_W, 32'h0000_0002, 2'b00, 0, 0, 1'b0, 1'b0);

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a;
         logic [2:0]  f3;
         a = $urandom;
         if ($urandom_range(0, 1) == 0) begin
            f3 = ld_f3[$urandom_range(0, 4)];
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            do_load($sformatf("rnd%0d_ld", i), a, f3, $urandom, 2'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom), 1'($urandom));
         end else begin
            f3 = 3'($urandom_range(0, 2));
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            do_store($sformatf("rnd%0d_st", i), a, f3, $urandom, 2'($urandom),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
